// File: rtl/mem_read_demux_pkg.sv
// Shared constants for the memory read distribution path.
package mem_demux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic DEST_MDR = 1'b0;
    localparam logic DEST_IR  = 1'b1;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_SPUR = 2'b01,
        ERR_BUSY = 2'b10,
        ERR_TMO  = 2'b11
    } err_e;

    // Wait counter width; covers the full TIMEOUT range up to 255.
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/mem_read_demux_if.sv
// Request/response and register-handshake bundle between memory, demux and control unit.
interface mem_read_demux_if #(
    parameter int unsigned N = 32
) ();

    logic         req;
    logic         Sel;
    logic [N-1:0] mem_rdata;
    logic         mem_rvalid;
    logic         busy;
    logic [N-1:0] ir_out;
    logic         ir_valid;
    logic         ir_ack;
    logic [N-1:0] mdr_out;
    logic         mdr_valid;
    logic         mdr_ack;
    logic         err;
    logic [1:0]   err_code;

    modport master (
        output req, Sel, mem_rdata, mem_rvalid, ir_ack, mdr_ack,
        input  busy, ir_out, ir_valid, mdr_out, mdr_valid, err, err_code
    );

    modport slave (
        input  req, Sel, mem_rdata, mem_rvalid, ir_ack, mdr_ack,
        output busy, ir_out, ir_valid, mdr_out, mdr_valid, err, err_code
    );

endinterface

// File: rtl/mem_read_demux_holding_reg.sv
// Holding register with valid/ack handshake; a write beats a same-cycle ack.
module holding_reg #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [N-1:0] wdata,
    input  logic         ack,
    output logic [N-1:0] data,
    output logic         valid
);

    // Data/valid update: write sets, ack alone clears, ack on empty is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (wr) begin
            data  <= wdata;
            valid <= 1'b1;
        end else if (ack) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_read_demux.sv
// Routes one outstanding memory read into IR or MDR and flags protocol violations.
module mem_read_demux
    import mem_demux_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    mem_read_demux_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             dest_q, dest_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             err_q, err_d;
    err_e             code_q, code_d;
    logic             ir_wr_c, mdr_wr_c;
    logic [N-1:0]     ir_data, mdr_data;
    logic             ir_vld, mdr_vld;

    // State, destination, wait counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dest_q  <= DEST_MDR;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_WAIT);
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Next state: accept in IDLE, retire or chain a request on response, abort at deadline.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    state_d = ST_WAIT;
                    dest_d  = bus.Sel;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (bus.req) begin
                        dest_d = bus.Sel;
                        cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: register write strobes and error events (timeout outranks req-while-busy).
    always_comb begin
        err_d    = 1'b0;
        code_d   = code_q;
        ir_wr_c  = 1'b0;
        mdr_wr_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mem_rvalid) begin
                    err_d  = 1'b1;
                    code_d = ERR_SPUR;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    ir_wr_c  = (dest_q == DEST_IR);
                    mdr_wr_c = (dest_q == DEST_MDR);
                end else if (cnt_q == CNT_LAST) begin
                    err_d  = 1'b1;
                    code_d = ERR_TMO;
                end else if (bus.req) begin
                    err_d  = 1'b1;
                    code_d = ERR_BUSY;
                end
            end
            default: ;
        endcase
    end

    holding_reg #(.N(N)) u_ir (
        .clk   (clk),
        .reset (reset),
        .wr    (ir_wr_c),
        .wdata (bus.mem_rdata),
        .ack   (bus.ir_ack),
        .data  (ir_data),
        .valid (ir_vld)
    );

    holding_reg #(.N(N)) u_mdr (
        .clk   (clk),
        .reset (reset),
        .wr    (mdr_wr_c),
        .wdata (bus.mem_rdata),
        .ack   (bus.mdr_ack),
        .data  (mdr_data),
        .valid (mdr_vld)
    );

    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
    assign bus.ir_out    = ir_data;
    assign bus.ir_valid  = ir_vld;
    assign bus.mdr_out   = mdr_data;
    assign bus.mdr_valid = mdr_vld;

endmodule

// File: tb/tb_mem_read_demux.sv
// Bench for mem_read_demux: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_read_demux;

    localparam int unsigned N   = 32;
    localparam int unsigned TMO = 4;
    localparam int unsigned VW  = 2 * N + 6;

    logic clk = 1'b0;
    logic reset;

    mem_read_demux_if #(.N(N)) bus ();

    mem_read_demux #(.N(N), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: a pending request with an absolute deadline edge, plus two mailboxes.
    bit           m_pend;
    bit           m_dest;
    int           m_deadline;
    logic [N-1:0] m_ir, m_mdr;
    bit           m_irv, m_mdrv, m_err;
    logic [1:0]   m_code;

    function automatic logic [VW-1:0] model_vec();
        return {m_pend, m_irv, m_mdrv, m_err, m_code, m_ir, m_mdr};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.busy, bus.ir_valid, bus.mdr_valid, bus.err, bus.err_code, bus.ir_out, bus.mdr_out};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return 1 time unit after it.
    task automatic step(input logic r, input logic s, input logic [N-1:0] d,
                        input logic v, input logic ia, input logic ma);
        bit wi, wm;
        bus.req = r; bus.Sel = s; bus.mem_rdata = d; bus.mem_rvalid = v;
        bus.ir_ack = ia; bus.mdr_ack = ma;
        @(posedge clk);
        wi = 1'b0; wm = 1'b0;
        if (reset) begin
            m_pend = 0; m_dest = 0; m_deadline = 0; m_ir = '0; m_mdr = '0;
            m_irv = 0; m_mdrv = 0; m_err = 0; m_code = 2'b00;
        end else begin
            m_err = 0;
            if (m_pend) begin
                if (v) begin
                    if (m_dest) wi = 1'b1; else wm = 1'b1;
                    if (r) begin m_dest = s; m_deadline = cyc + TMO; end
                    else m_pend = 0;
                end else if (cyc == m_deadline) begin
                    m_pend = 0; m_err = 1; m_code = 2'b11;
                end else if (r) begin
                    m_err = 1; m_code = 2'b10;
                end
            end else begin
                if (v) begin m_err = 1; m_code = 2'b01; end
                if (r) begin m_pend = 1; m_dest = s; m_deadline = cyc + TMO; end
            end
            if (wi) begin m_ir = d; m_irv = 1; end else if (ia) m_irv = 0;
            if (wm) begin m_mdr = d; m_mdrv = 1; end else if (ma) m_mdrv = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        n_cmp++;
        if (dut_vec() !== '0) begin
            $display("FAIL reset_state: got %h want 0", dut_vec()); n_fail++;
        end
        reset = 1'b0;
        idle();
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            $display("FAIL reset_idle: got %h want %h", dut_vec(), model_vec()); n_fail++;
        end
    endtask

    task automatic test_ir_read();
        step(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.busy !== 1'b1) begin $display("FAIL ir_busy_set: got %b want 1", bus.busy); n_fail++; end
        idle();
        step(1'b0, 1'b0, 32'h8C22_0004, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.ir_out, bus.ir_valid, bus.mdr_valid, bus.busy} !== {32'h8C22_0004, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL ir_read: got ir=%h v=%b mv=%b busy=%b want ir=8c220004 v=1 mv=0 busy=0",
                     bus.ir_out, bus.ir_valid, bus.mdr_valid, bus.busy);
            n_fail++;
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.mdr_out, bus.mdr_valid, bus.busy, bus.err} !== {32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL b2b_first: got mdr=%h v=%b busy=%b err=%b want deadbeef 1 1 0",
                     bus.mdr_out, bus.mdr_valid, bus.busy, bus.err);
            n_fail++;
        end
        step(1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.ir_out, bus.mdr_out, bus.busy, bus.err} !== {32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            $display("FAIL b2b_second: got ir=%h mdr=%h busy=%b err=%b want 12345678 deadbeef 0 0",
                     bus.ir_out, bus.mdr_out, bus.busy, bus.err);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] ir_s, mdr_s;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < int'(TMO); i++) begin
            idle();
            n_cmp++;
            if ({bus.err, bus.busy} !== 2'b01) begin
                $display("FAIL tmo_wait%0d: got err=%b busy=%b want 0 1", i, bus.err, bus.busy); n_fail++;
            end
        end
        idle();
        n_cmp++;
        if ({bus.err, bus.err_code, bus.busy} !== 4'b1110) begin
            $display("FAIL tmo_fire: got err=%b code=%b busy=%b want 1 11 0", bus.err, bus.err_code, bus.busy);
            n_fail++;
        end
        idle();
        n_cmp++;
        if ({bus.err, bus.err_code} !== 3'b011) begin
            $display("FAIL tmo_hold: got err=%b code=%b want 0 11", bus.err, bus.err_code); n_fail++;
        end
        ir_s = bus.ir_out; mdr_s = bus.mdr_out;
        step(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.err, bus.err_code, bus.ir_out, bus.mdr_out} !== {1'b1, 2'b01, 32'h1234_5678, 32'hDEAD_BEEF}) begin
            $display("FAIL spurious: got err=%b code=%b ir=%h mdr=%h want 1 01 %h %h",
                     bus.err, bus.err_code, bus.ir_out, bus.mdr_out, ir_s, mdr_s);
            n_fail++;
        end
    endtask

    task automatic test_busy_req();
        step(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.err, bus.err_code, bus.busy} !== 4'b1101) begin
            $display("FAIL busy_req: got err=%b code=%b busy=%b want 1 10 1", bus.err, bus.err_code, bus.busy);
            n_fail++;
        end
        step(1'b0, 1'b0, 32'hA5A5_5A5A, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.ir_out, bus.ir_valid, bus.mdr_out, bus.busy, bus.err} !==
            {32'hA5A5_5A5A, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            $display("FAIL busy_orig_lands: got ir=%h v=%b mdr=%h busy=%b err=%b want a5a55a5a 1 deadbeef 0 0",
                     bus.ir_out, bus.ir_valid, bus.mdr_out, bus.busy, bus.err);
            n_fail++;
        end
    endtask

    task automatic test_ack_write();
        step(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h1111_0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0000_ABCD, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.ir_valid, bus.ir_out} !== {1'b1, 32'h0000_ABCD}) begin
            $display("FAIL ack_vs_write: got v=%b ir=%h want 1 0000abcd", bus.ir_valid, bus.ir_out); n_fail++;
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.ir_valid !== 1'b0) begin $display("FAIL ack_clear: got v=%b want 0", bus.ir_valid); n_fail++; end
    endtask

    task automatic test_reset_wait();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        n_cmp++;
        if (dut_vec() !== '0) begin $display("FAIL reset_wait: got %h want 0", dut_vec()); n_fail++; end
        step(1'b0, 1'b0, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (dut_vec() !== {4'b0001, 2'b01, 64'h0}) begin
            $display("FAIL late_resp: got %h want %h", dut_vec(), {4'b0001, 2'b01, 64'h0}); n_fail++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            step(($urandom_range(0, 2) == 0), 1'($urandom), $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec()); n_fail++;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 1'b0; bus.Sel = 1'b0; bus.mem_rdata = '0; bus.mem_rvalid = 1'b0;
        bus.ir_ack = 1'b0; bus.mdr_ack = 1'b0;
        test_reset();
        test_ir_read();
        test_back_to_back();
        test_timeout();
        test_busy_req();
        test_ack_write();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_read_demux.md
Name: mem_read_demux

Overview:
- Distribution end of the shared instruction/data memory path in the multicycle core.
- Accepts one outstanding memory read request, tagged with a destination select.
- When the memory returns data, routes it into either the Instruction Register (IR) or the Memory Data Register (MDR), each with a valid/ack handshake toward the control unit.
- Detects protocol violations (spurious response, request while busy, response timeout).

Parameters:
N, 32, data width of the memory word and of both holding registers
TIMEOUT, 8, maximum WAIT cycles allowed for a response before abort (legal range 2..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  1  read request issued to memory this cycle
Sel  input  1  destination for this request: 0 = MDR, 1 = IR; sampled only when req is accepted
mem_rdata  input  N  memory read data
mem_rvalid  input  1  mem_rdata is valid this cycle
busy  output  1  request outstanding (state WAIT)
ir_out  output  N  Instruction Register contents
ir_valid  output  1  ir_out holds unconsumed data
ir_ack  input  1  consumer has taken ir_out
mdr_out  output  N  Memory Data Register contents
mdr_valid  output  1  mdr_out holds unconsumed data
mdr_ack  input  1  consumer has taken mdr_out
err  output  1  one-cycle error pulse
err_code  output  2  valid when err = 1: 01 spurious rvalid, 10 req while busy, 11 timeout

Behaviour:
- Reset: one clock, synchronous, active-high. Reset gives state = IDLE, busy = 0, ir_out = 0, mdr_out = 0, ir_valid = 0, mdr_valid = 0, err = 0, err_code = 00, dest_q = 0, wait counter = 0.
- Reset asserted mid-WAIT aborts the outstanding request. A response arriving after reset is treated as spurious.
- FSM has two states:
  - IDLE: req = 1 → capture Sel into dest_q, clear counter, go to WAIT.
  - WAIT: mem_rvalid = 1 → write mem_rdata into the register selected by dest_q and set its valid.
    - If req = 1 in the same cycle, it is accepted back-to-back: capture the new Sel, clear the counter, stay in WAIT. Otherwise go to IDLE.
  - WAIT, no mem_rvalid, counter == TIMEOUT-1 → go to IDLE, err pulse with code 11.
  - WAIT, no mem_rvalid, otherwise → counter increments.
- Response window: a response is accepted in any of the TIMEOUT cycles after the request cycle. Minimum latency is 1 cycle (response in the cycle after req).
- busy = (state == WAIT), registered.
- Register write: data and valid appear one cycle after the mem_rvalid cycle.
- Valid flags:
  - Set on write; cleared on ack when no simultaneous write.
  - Write and ack on the same register in the same cycle: the write wins, valid stays 1 and data is updated.
  - Write while valid = 1 and not acked: data is overwritten, valid stays 1, no error.
  - Ack while valid = 0: ignored.
- Error conditions:
  - req while WAIT and no mem_rvalid: req is ignored, err code 10. Timeout has priority (code 11) if both occur in the same cycle.
  - mem_rvalid in IDLE: data is discarded, err code 01. A req in the same cycle is still accepted.
- err is registered, high for exactly one cycle per error event. err_code holds its last value while err = 0.
- The non-selected register never changes on a write.

Decomposition:
- Shared package (mem_demux_pkg):
  - state encoding constants ST_IDLE and ST_WAIT.
  - destination constants DEST_MDR = 0 and DEST_IR = 1.
  - error codes ERR_NONE, ERR_SPUR, ERR_BUSY, ERR_TMO.
- Natural sub-module: holding_reg (N-bit register with write/ack/valid logic and write-over-ack priority), instantiated twice for IR and MDR.
- FSM, counter and error logic stay in the top level.

Test Plan:
1. Reset, then req with Sel=1; mem_rvalid with mem_rdata=0x8C220004 two cycles later → ir_out = 0x8C220004, ir_valid = 1 next cycle; mdr_valid = 0; busy 1→0.
2. req with Sel=0; response 0xDEADBEEF in the next cycle, with req Sel=1 in the same cycle; response 0x12345678 one cycle later → mdr_out = 0xDEADBEEF, ir_out = 0x12345678, no err.
3. TIMEOUT=4, req with no response → err = 1, err_code = 11 exactly 4 cycles after the req cycle; busy = 0. A later mem_rvalid → err_code = 01, registers unchanged.
4. Request outstanding, second req with no rvalid → err_code = 10; the original response still lands in the correct register.
5. ir_valid = 1, and ir_ack coincides with a new IR write of 0x0000ABCD → ir_valid stays 1, ir_out = 0x0000ABCD. Next cycle ir_ack alone → ir_valid = 0.
6. Reset asserted in WAIT, then mem_rvalid → busy = 0, valids = 0, err_code = 01, outputs = 0.
